uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at mid-bit, samples data
// at bit centres and hands good bytes over through a one-deep valid/ready holding register.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk12,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [2:0]       bidx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;

  // Receive FSM, synchroniser and holding register in one clocked process.
  always_ff @(posedge clk12) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      bcnt_q       <= '0;
      bidx_q       <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer handshake; a same-cycle delivery below takes precedence.
      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            bcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (bcnt_q == MID_CNT) begin
            if (!rx_s_q) begin
              state_q <= S_DATA;
              bcnt_q  <= '0;
              bidx_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            bcnt_q <= bcnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bcnt_q == TICK_CNT) begin
            bcnt_q  <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bidx_q  <= bidx_q + 3'd1;
            if (bidx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            bcnt_q <= bcnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bcnt_q == TICK_CNT) begin
            bcnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              // A full register only takes the new byte if the old one leaves this cycle.
              if (!data_valid_q || data_ready) begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              state_q     <= S_WAIT_IDLE;
              frame_err_q <= 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: drives 8N1 frames and checks the
// holding register, handshake, glitch rejection, framing error, overrun and reset.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  logic       clk12 = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_asserts = 0;
  int n_fail    = 0;

  int   cyc       = 0;
  int   fe_cnt    = 0;
  int   ov_cnt    = 0;
  int   both_cnt  = 0;
  int   dv_rises  = 0;
  int   dv_hi     = 0;
  int   rise_cyc  = 0;
  int   last_t0   = 0;
  bit   busy_seen = 1'b0;
  logic dv_prev   = 1'b0;
  logic [7:0] acc_q[$];

  int r0;
  int fe0;
  int ov0;
  logic [7:0] byte96;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk12      (clk12),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk12 = ~clk12;

  // Output monitor, 2 time units after each rising edge.
  always begin
    @(posedge clk12);
    #2;
    cyc++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (busy) busy_seen = 1'b1;
    if (data_valid) dv_hi++;
    if (data_valid && !dv_prev) begin
      dv_rises++;
      rise_cyc = cyc;
    end
    if (data_valid && data_ready) acc_q.push_back(data);
    dv_prev = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk12);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    last_t0 = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_b;
    wait_cyc(CPB);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    wait_cyc(1);
    data_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b0;
    wait_cyc(3);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // 1: single frame held until consumed
    send_frame(8'hA5, 1'b1);
    chk("t1_valid", 32'(data_valid), 32'h1);
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_latency", 32'((rise_cyc - last_t0 >= 77) && (rise_cyc - last_t0 <= 80)), 32'h1);
    wait_cyc(20);
    chk("t1_hold_valid", 32'(data_valid), 32'h1);
    chk("t1_hold_data", 32'(data), 32'hA5);
    consume();
    chk("t1_consumed", 32'(data_valid), 32'h0);
    chk("t1_no_ferr", 32'(fe_cnt), 32'h0);
    chk("t1_no_ovr", 32'(ov_cnt), 32'h0);

    // 2: short low glitch rejected at mid-start
    wait_cyc(10);
    busy_seen = 1'b0;
    r0 = dv_rises;
    rx = 1'b0;
    wait_cyc(2);
    rx = 1'b1;
    wait_cyc(12);
    chk("t2_busy_seen", 32'(busy_seen), 32'h1);
    chk("t2_busy_back", 32'(busy), 32'h0);
    chk("t2_no_valid", 32'(dv_rises - r0), 32'h0);
    chk("t2_no_ferr", 32'(fe_cnt), 32'h0);
    chk("t2_no_ovr", 32'(ov_cnt), 32'h0);

    // 3: bad stop bit, line held low, then a clean frame
    wait_cyc(10);
    r0 = dv_rises;
    send_frame(8'h3C, 1'b0);
    wait_cyc(40);
    chk("t3_busy_hold", 32'(busy), 32'h1);
    chk("t3_ferr_once", 32'(fe_cnt), 32'h1);
    chk("t3_no_valid", 32'(dv_rises - r0), 32'h0);
    rx = 1'b1;
    wait_cyc(10);
    chk("t3_idle", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1);
    wait_cyc(2);
    chk("t3_valid", 32'(data_valid), 32'h1);
    chk("t3_data", 32'(data), 32'h55);
    chk("t3_one_valid", 32'(dv_rises - r0), 32'h1);
    chk("t3_ferr_total", 32'(fe_cnt), 32'h1);
    consume();

    // 4: back-to-back frames with no consumer -> overrun
    wait_cyc(10);
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cyc(2);
    chk("t4_valid", 32'(data_valid), 32'h1);
    chk("t4_data_kept", 32'(data), 32'h11);
    chk("t4_ovr_once", 32'(ov_cnt - ov0), 32'h1);
    chk("t4_no_ferr", 32'(fe_cnt), 32'h1);
    consume();

    // 5: always-ready consumer, back-to-back frames
    wait_cyc(10);
    acc_q.delete();
    dv_hi = 0;
    ov0 = ov_cnt;
    data_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    wait_cyc(4);
    chk("t5_count", 32'(acc_q.size()), 32'd3);
    chk("t5_pulse_cycles", 32'(dv_hi), 32'd3);
    chk("t5_byte0", (acc_q.size() > 0) ? 32'(acc_q[0]) : 32'hDEAD, 32'h00);
    chk("t5_byte1", (acc_q.size() > 1) ? 32'(acc_q[1]) : 32'hDEAD, 32'hFF);
    chk("t5_byte2", (acc_q.size() > 2) ? 32'(acc_q[2]) : 32'hDEAD, 32'h80);
    chk("t5_no_ovr", 32'(ov_cnt - ov0), 32'h0);
    chk("t5_idle_valid", 32'(data_valid), 32'h0);
    data_ready = 1'b0;

    // 6: reset mid-frame discards frame and held byte
    wait_cyc(10);
    send_frame(8'h5A, 1'b1);
    wait_cyc(2);
    chk("t6_held_valid", 32'(data_valid), 32'h1);
    chk("t6_held_data", 32'(data), 32'h5A);
    byte96 = 8'h96;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = byte96[i];
      wait_cyc(CPB);
    end
    rx = byte96[4];
    wait_cyc(4);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rst = 1'b1;
    wait_cyc(1);
    chk("t6_rst_data", 32'(data), 32'h00);
    chk("t6_rst_valid", 32'(data_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err), 32'h0);
    chk("t6_rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    rx = 1'b1;
    r0 = dv_rises;
    wait_cyc(20);
    chk("t6_quiet_busy", 32'(busy), 32'h0);
    chk("t6_quiet_valid", 32'(dv_rises - r0), 32'h0);
    send_frame(8'h4B, 1'b1);
    wait_cyc(2);
    chk("t6_valid", 32'(data_valid), 32'h1);
    chk("t6_data", 32'(data), 32'h4B);
    chk("t6_one_valid", 32'(dv_rises - r0), 32'h1);
    chk("t6_no_ferr", 32'(fe_cnt - fe0), 32'h0);
    chk("t6_no_ovr", 32'(ov_cnt - ov0), 32'h0);

    chk("never_both_flags", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
